// File: rtl/ped_button_cond.sv
// Pedestrian push-button conditioner: synchronizes the raw button, debounces it
// with a four-state FSM, emits a one-cycle strobe per accepted press and counts
// presses during RED, raising a held green request once the target is reached.
module ped_button_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PRESS_TARGET    = 3
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn,
  input  logic [1:0] light_state,
  output logic       btn_clean,
  output logic       btn_pulse,
  output logic [1:0] press_cnt,
  output logic       req_green
);

  localparam int                CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [1:0]        TARGET   = 2'(PRESS_TARGET);
  localparam logic [1:0]        LIGHT_RED = 2'd0;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_WAIT   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_WAIT   = 2'd3
  } db_state_t;

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  db_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            btn_clean_q, btn_clean_d;
  logic            btn_pulse_q, btn_pulse_d;
  logic [1:0]      press_cnt_q, press_cnt_d;
  logic            req_green_q, req_green_d;

  // Count one more press, never past the target so the 2-bit count cannot wrap.
  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    logic [2:0] nxt;
    nxt = {1'b0, cnt} + 3'd1;
    if (nxt > {1'b0, TARGET}) begin
      return TARGET;
    end
    return nxt[1:0];
  endfunction

  // Two-flop synchronizer; only the second stage is used downstream.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  // Debounce FSM next state, stability counter and accepted-press event.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    btn_pulse_d = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        if (sync2_q) begin
          state_d = RISE_WAIT;
          cnt_d   = '0;
        end
      end
      RISE_WAIT: begin
        if (!sync2_q) begin
          state_d = LOW_STABLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = HIGH_STABLE;
          btn_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!sync2_q) begin
          state_d = FALL_WAIT;
          cnt_d   = '0;
        end
      end
      FALL_WAIT: begin
        if (sync2_q) begin
          state_d = HIGH_STABLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOW_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
    btn_clean_d = (state_d == HIGH_STABLE) || (state_d == FALL_WAIT);
  end

  // Press counting during RED; leaving RED clears everything and wins over a press.
  always_comb begin
    press_cnt_d = press_cnt_q;
    req_green_d = req_green_q;
    if (light_state != LIGHT_RED) begin
      press_cnt_d = 2'd0;
      req_green_d = 1'b0;
    end else if (btn_pulse_d && !req_green_q) begin
      press_cnt_d = sat_inc(press_cnt_q);
      if (({1'b0, press_cnt_q} + 3'd1) == {1'b0, TARGET}) begin
        req_green_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= LOW_STABLE;
      cnt_q       <= '0;
      btn_clean_q <= 1'b0;
      btn_pulse_q <= 1'b0;
      press_cnt_q <= 2'd0;
      req_green_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_clean_q <= btn_clean_d;
      btn_pulse_q <= btn_pulse_d;
      press_cnt_q <= press_cnt_d;
      req_green_q <= req_green_d;
    end
  end

  assign btn_clean = btn_clean_q;
  assign btn_pulse = btn_pulse_q;
  assign press_cnt = press_cnt_q;
  assign req_green = req_green_q;

endmodule

// File: tb/tb_ped_button_cond.sv
// Bench for ped_button_cond: two instances (target 3 and target 1) driven by the
// same directed stimulus, checked every cycle against a run-length model, plus
// literal expectations at the key edges.
module tb_ped_button_cond;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       btn = 1'b0;
  logic [1:0] light_state = 2'd0;

  logic       a_clean, a_pulse, a_req;
  logic [1:0] a_cnt;
  logic       b_clean, b_pulse, b_req;
  logic [1:0] b_cnt;

  int tests = 0;
  int fails = 0;

  ped_button_cond #(.DEBOUNCE_CYCLES(D), .PRESS_TARGET(3)) dut_a (
    .clk(clk), .res(res), .btn(btn), .light_state(light_state),
    .btn_clean(a_clean), .btn_pulse(a_pulse), .press_cnt(a_cnt), .req_green(a_req)
  );

  ped_button_cond #(.DEBOUNCE_CYCLES(D), .PRESS_TARGET(1)) dut_b (
    .clk(clk), .res(res), .btn(btn), .light_state(light_state),
    .btn_clean(b_clean), .btn_pulse(b_pulse), .press_cnt(b_cnt), .req_green(b_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the debounced level flips once s has disagreed with it on D+1
  // consecutive edges; any agreeing edge restarts the run.
  int   tgt [2] = '{3, 1};
  logic m_s1 [2] = '{1'b0, 1'b0};
  logic m_s2 [2] = '{1'b0, 1'b0};
  logic m_l  [2] = '{1'b0, 1'b0};
  int   m_k  [2] = '{0, 0};
  logic m_p  [2] = '{1'b0, 1'b0};
  int   m_c  [2] = '{0, 0};
  logic m_r  [2] = '{1'b0, 1'b0};
  logic t_l, t_p, t_r;
  int   t_k, t_c;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!res) begin
        m_s1[i] <= 1'b0; m_s2[i] <= 1'b0; m_l[i] <= 1'b0; m_k[i] <= 0;
        m_p[i]  <= 1'b0; m_c[i]  <= 0;    m_r[i] <= 1'b0;
      end else begin
        t_l = m_l[i]; t_k = m_k[i]; t_p = 1'b0;
        if (m_s2[i] != t_l) begin
          t_k = t_k + 1;
          if (t_k == D + 1) begin
            t_l = m_s2[i];
            t_k = 0;
            t_p = m_s2[i];
          end
        end else begin
          t_k = 0;
        end
        t_c = m_c[i]; t_r = m_r[i];
        if (light_state != 2'd0) begin
          t_c = 0; t_r = 1'b0;
        end else if (t_p && !t_r) begin
          t_c = t_c + 1;
          if (t_c == tgt[i]) t_r = 1'b1;
        end
        m_s2[i] <= m_s1[i]; m_s1[i] <= btn;
        m_l[i] <= t_l; m_k[i] <= t_k; m_p[i] <= t_p;
        m_c[i] <= t_c; m_r[i] <= t_r;
      end
    end
  end

  // Per-cycle comparison on the falling edge, once the first edge has passed.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("a_clean", int'(a_clean), int'(m_l[0]));
      chk("a_pulse", int'(a_pulse), int'(m_p[0]));
      chk("a_cnt",   int'(a_cnt),   m_c[0]);
      chk("a_req",   int'(a_req),   int'(m_r[0]));
      chk("b_clean", int'(b_clean), int'(m_l[1]));
      chk("b_pulse", int'(b_pulse), int'(m_p[1]));
      chk("b_cnt",   int'(b_cnt),   m_c[1]);
      chk("b_req",   int'(b_req),   int'(m_r[1]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int exp_cnt, input int exp_req, input string tag);
    btn = 1'b1;
    step(7);
    chk({tag, "_pulse"}, int'(a_pulse), 1);
    chk({tag, "_cnt"},   int'(a_cnt),   exp_cnt);
    chk({tag, "_req"},   int'(a_req),   exp_req);
    btn = 1'b0;
    step(9);
  endtask

  initial begin
    // Reset state
    res = 1'b0; btn = 1'b0; light_state = 2'd0;
    step(3);
    chk("rst_clean", int'(a_clean), 0);
    chk("rst_pulse", int'(a_pulse), 0);
    chk("rst_cnt",   int'(a_cnt),   0);
    chk("rst_req",   int'(a_req),   0);
    res = 1'b1;
    step(2);

    // Clean press: rises on edge 7, falls 7 edges after release
    btn = 1'b1;
    step(6);
    chk("press_clean_e6", int'(a_clean), 0);
    chk("press_pulse_e6", int'(a_pulse), 0);
    step(1);
    chk("press_clean_e7", int'(a_clean), 1);
    chk("press_pulse_e7", int'(a_pulse), 1);
    chk("press_cnt_e7",   int'(a_cnt),   1);
    chk("b_req_e7",       int'(b_req),   1);
    step(1);
    chk("press_pulse_e8", int'(a_pulse), 0);
    step(12);
    btn = 1'b0;
    step(6);
    chk("rel_clean_e6", int'(a_clean), 1);
    step(1);
    chk("rel_clean_e7", int'(a_clean), 0);
    chk("rel_pulse_e7", int'(a_pulse), 0);
    step(4);

    // Leave RED briefly to clear the count
    light_state = 2'd1;
    step(2);
    chk("clr_cnt", int'(a_cnt), 0);
    chk("clr_req_b", int'(b_req), 0);
    light_state = 2'd0;
    step(2);

    // Bounce: toggles every 2 cycles for 16 cycles
    for (int i = 0; i < 4; i++) begin
      btn = 1'b1; step(2);
      btn = 1'b0; step(2);
    end
    step(10);
    chk("bounce_clean", int'(a_clean), 0);
    chk("bounce_cnt",   int'(a_cnt),   0);

    // Three presses raise the request; the fourth is ignored
    press_release(1, 0, "p1");
    press_release(2, 0, "p2");
    press_release(3, 1, "p3");
    press_release(3, 1, "p4");

    // Leaving RED clears request and count on the next edge
    light_state = 2'd1;
    step(1);
    chk("green_req", int'(a_req), 0);
    chk("green_cnt", int'(a_cnt), 0);
    press_release(0, 0, "pg");

    // Pulse on the same edge light_state becomes YELLOW
    light_state = 2'd0;
    step(2);
    btn = 1'b1;
    step(6);
    light_state = 2'd2;
    step(1);
    chk("sim_pulse", int'(a_pulse), 1);
    chk("sim_cnt",   int'(a_cnt),   0);
    chk("sim_req",   int'(a_req),   0);
    btn = 1'b0;
    step(9);
    light_state = 2'd0;
    step(2);

    // Reset in the middle of a held press forces a full new debounce
    btn = 1'b1;
    step(4);
    res = 1'b0;
    step(1);
    chk("mid_rst_clean", int'(a_clean), 0);
    chk("mid_rst_pulse", int'(a_pulse), 0);
    chk("mid_rst_cnt",   int'(a_cnt),   0);
    res = 1'b1;
    step(6);
    chk("post_rst_pulse_e6", int'(a_pulse), 0);
    step(1);
    chk("post_rst_pulse_e7", int'(a_pulse), 1);
    chk("post_rst_clean_e7", int'(a_clean), 1);
    chk("post_rst_cnt_e7",   int'(a_cnt),   1);
    chk("post_rst_b_req",    int'(b_req),   1);
    btn = 1'b0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ped_button_cond.md
PED_BUTTON_COND -- requirements
Module: ped_button_cond

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning stable-input cycles required before a level change is accepted (20 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 The module SHALL have parameter PRESS_TARGET, default 3, meaning the number of accepted presses during RED that raise a green request; legal range 1..3.
REQ-003 clk  input  1  system clock (50 MHz), all logic on its rising edge.
REQ-004 res  input  1  reset, synchronous, active-low.
REQ-005 btn  input  1  raw pedestrian push-button, asynchronous to clk, bouncing, active-high.
REQ-006 light_state  input  2  current traffic-light state (0=RED, 1=GREEN, 2=YELLOW, 3=invalid).
REQ-007 btn_clean  output  1  debounced button level, registered.
REQ-008 btn_pulse  output  1  one-cycle strobe on each accepted press (debounced rising edge), registered.
REQ-009 press_cnt  output  2  accepted presses counted during the current RED phase.
REQ-010 req_green  output  1  level request to the traffic-light controller to leave RED early.

Function
REQ-011 btn SHALL pass through a two-flop synchronizer; only the second-stage output (s) SHALL be used downstream.
REQ-012 The debouncer SHALL be a 4-state FSM: LOW_STABLE, RISE_WAIT, HIGH_STABLE, FALL_WAIT, with a counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 LOW_STABLE: s=1 -> RISE_WAIT with counter=0; else stay.
REQ-014 RISE_WAIT: s=0 -> LOW_STABLE (bounce rejected); s=1 and counter=DEBOUNCE_CYCLES-1 -> HIGH_STABLE; else counter+1.
REQ-015 HIGH_STABLE: s=0 -> FALL_WAIT with counter=0; else stay.
REQ-016 FALL_WAIT: s=1 -> HIGH_STABLE; s=0 and counter=DEBOUNCE_CYCLES-1 -> LOW_STABLE; else counter+1.
REQ-017 btn_clean SHALL be 1 exactly while FSM is in HIGH_STABLE or FALL_WAIT.
REQ-018 btn_pulse SHALL be 1 for exactly the one cycle following the RISE_WAIT -> HIGH_STABLE transition; never on falling edges.
REQ-019 Latency: with btn held high, btn_clean and btn_pulse SHALL rise on the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge sampling btn=1 as 1.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES cycles (as seen at s) SHALL produce no change on btn_clean and no btn_pulse.
REQ-021 When light_state != RED (including 3): press_cnt SHALL be 0 and req_green SHALL be 0 on the next edge; this clear has priority over a simultaneous btn_pulse.
REQ-022 When light_state = RED and req_green=0, btn_pulse SHALL increment press_cnt; if press_cnt+1 = PRESS_TARGET, req_green SHALL be set on the same edge and press_cnt SHALL hold PRESS_TARGET.
REQ-023 While req_green=1 and light_state=RED, further btn_pulse SHALL be ignored; press_cnt SHALL never exceed PRESS_TARGET (no 2-bit wrap).
REQ-024 req_green SHALL remain 1 until light_state leaves RED, so a slow (1 Hz) consumer samples it reliably.

Reset
REQ-025 On a rising clk edge with res=0: both synchronizer flops=0, FSM=LOW_STABLE, counter=0, btn_clean=0, btn_pulse=0, press_cnt=0, req_green=0.
REQ-026 Reset asserted mid-debounce or with btn held high SHALL apply REQ-025; a still-held button SHALL then require a full new debounce before btn_pulse (no pulse lost-and-replayed from pre-reset state).

Verification (DEBOUNCE_CYCLES=4, PRESS_TARGET=3 unless stated)
REQ-027 Clean press: light_state=0, btn 0->1 held 20 cycles -> btn_clean=1 and single btn_pulse on edge 7, press_cnt=1; btn released -> btn_clean=0 on edge 7 after release, no pulse.
REQ-028 Bounce: btn toggles 1/0 every 2 cycles for 16 cycles then stays 0 -> btn_clean stays 0, no btn_pulse, press_cnt=0.
REQ-029 Three presses during RED -> press_cnt 1,2,3; req_green=1 on the third btn_pulse edge; fourth press -> press_cnt stays 3, req_green stays 1.
REQ-030 Clear: req_green=1, light_state 0->1 -> req_green=0, press_cnt=0 next edge; press while light_state=1 -> btn_pulse=1, press_cnt stays 0.
REQ-031 Simultaneity: btn_pulse on same edge light_state becomes 2 -> press_cnt=0, req_green=0.
REQ-032 Reset mid-RISE_WAIT with btn held -> all outputs 0; after res=1, btn_pulse on edge 7 after release of reset; PRESS_TARGET=1 run -> req_green on first pulse.
